// File: rtl/xc_aes_pkg.sv
// Shared AES definitions: FSM encoding, byte lanes and GF(2^8) helpers
// used by the SubBytes unit and the S-box.
package xc_aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [1:0] LANE0 = 2'd0;
    localparam logic [1:0] LANE1 = 2'd1;
    localparam logic [1:0] LANE2 = 2'd2;
    localparam logic [1:0] LANE3 = 2'd3;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // a^254 == a^-1 (and maps 0 to 0): build a^127 by square-and-multiply,
    // then square once more.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] t;
        t = a;
        for (int i = 0; i < 6; i++) begin
            t = gf_mul(gf_mul(t, t), a);
        end
        return gf_mul(t, t);
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b
             ^ {b[6:0], b[7]}
             ^ {b[5:0], b[7:6]}
             ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]}
             ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] b);
        return {b[6:0], b[7]}
             ^ {b[4:0], b[7:5]}
             ^ {b[1:0], b[7:2]}
             ^ 8'h05;
    endfunction

endpackage

// File: rtl/xc_aes_sbox.sv
// Combinational AES S-box: forward (enc=1) or inverse (enc=0),
// built from the field inverse and the (inverse) affine map.
module xc_aes_sbox
    import xc_aes_pkg::*;
(
    input  logic [7:0] in,
    input  logic       enc,
    output logic [7:0] out
);

    logic [7:0] pre;
    logic [7:0] inv;

    assign pre = enc ? in : inv_affine(in);
    assign inv = gf_inv(pre);
    assign out = enc ? affine(inv) : inv;

endmodule

// File: rtl/xc_aessub.sv
// XCrypto AES SubBytes unit: one shared S-box over 4 cycles (FAST=0)
// or four parallel S-boxes in a single cycle (FAST=1).
module xc_aessub
    import xc_aes_pkg::*;
#(
    parameter logic FAST = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] flush_data,
    input  logic        valid,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        enc,
    output logic        ready,
    output logic [31:0] result
);

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] res_q, res_d;

    logic [7:0] t [4];
    logic [7:0] s [4];

    assign t[LANE0] = rs1[7:0];
    assign t[LANE1] = rs1[15:8];
    assign t[LANE2] = rs2[23:16];
    assign t[LANE3] = rs2[31:24];

    logic unused_ok;
    assign unused_ok = ^{rs1[31:16], rs2[15:0]};

    generate
        if (FAST) begin : g_fast
            for (genvar i = 0; i < 4; i++) begin : g_lane
                xc_aes_sbox u_sbox (
                    .in  (t[i]),
                    .enc (enc),
                    .out (s[i])
                );
            end
        end else begin : g_slow
            logic [7:0] s_one;
            // cnt is 0 in IDLE, so the same mux feeds the first lane
            xc_aes_sbox u_sbox (
                .in  (t[cnt_q]),
                .enc (enc),
                .out (s_one)
            );
            assign s[LANE0] = s_one;
            assign s[LANE1] = s_one;
            assign s[LANE2] = s_one;
            assign s[LANE3] = s_one;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = 2'd0;
            res_d   = flush_data;
        end else if (!valid) begin
            state_d = ST_IDLE;
            cnt_d   = 2'd0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (FAST) begin
                        res_d   = {s[LANE3], s[LANE2], s[LANE1], s[LANE0]};
                        state_d = ST_DONE;
                    end else begin
                        res_d[7:0] = s[LANE0];
                        cnt_d      = 2'd1;
                        state_d    = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    res_d[{cnt_q, 3'b000} +: 8] = s[cnt_q];
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == LANE3) state_d = ST_DONE;
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            res_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    assign ready  = (state_q == ST_DONE) && valid;
    assign result = res_q;

endmodule

// File: tb/tb_xc_aessub.sv
// Directed bench for xc_aessub: slow (FAST=0) and fast (FAST=1)
// instances share stimulus; expected words are hand-computed.
module tb_xc_aessub;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] flush_data;
    logic        valid;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        enc;
    logic        ready_s, ready_f;
    logic [31:0] result_s, result_f;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    xc_aessub #(.FAST(1'b0)) u_slow (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .flush_data (flush_data),
        .valid      (valid),
        .rs1        (rs1),
        .rs2        (rs2),
        .enc        (enc),
        .ready      (ready_s),
        .result     (result_s)
    );

    xc_aessub #(.FAST(1'b1)) u_fast (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .flush_data (flush_data),
        .valid      (valid),
        .rs1        (rs1),
        .rs2        (rs2),
        .enc        (enc),
        .ready      (ready_f),
        .result     (result_f)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive one op on the slow unit, wait for ready, retire with flush.
    task automatic run_op(
        input  logic [31:0] a,
        input  logic [31:0] b,
        input  logic        e,
        output logic [31:0] res,
        output int          lat
    );
        rs1 = a; rs2 = b; enc = e;
        valid = 1'b1;
        lat = -1;
        res = 32'hx;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (ready_s) begin
                lat = c;
                res = result_s;
                break;
            end
        end
        flush = 1'b1;
        flush_data = 32'h0;
        tick();
        flush = 1'b0;
        valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        flush = 1'b0;
        flush_data = 32'h0;
        valid = 1'b0;
        rs1 = 32'h0; rs2 = 32'h0; enc = 1'b1;
        tick();
        tick();
        n_tests++;
        if (ready_s !== 1'b0 || result_s !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_slow: ready=%b result=%h, need 0/00000000",
                     ready_s, result_s);
        end
        n_tests++;
        if (ready_f !== 1'b0 || result_f !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_fast: ready=%b result=%h, need 0/00000000",
                     ready_f, result_f);
        end
        reset = 1'b1;
        tick();
    endtask

    // Per-cycle latency check on both builds.
    task automatic test_vectors(
        input string       name,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic        e,
        input logic [31:0] exp
    );
        rs1 = a; rs2 = b; enc = e;
        valid = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_tests++;
            if (ready_s !== (c == 4)) begin
                n_fail++;
                $display("FAIL %s_ready_slow c%0d: ready=%b need %b",
                         name, c, ready_s, (c == 4));
            end
            n_tests++;
            if (ready_f !== 1'b1) begin
                n_fail++;
                $display("FAIL %s_ready_fast c%0d: ready=%b need 1",
                         name, c, ready_f);
            end
            if (c == 1) begin
                n_tests++;
                if (result_f !== exp) begin
                    n_fail++;
                    $display("FAIL %s_fast: result=%h need %h",
                             name, result_f, exp);
                end
            end
        end
        n_tests++;
        if (result_s !== exp) begin
            n_fail++;
            $display("FAIL %s_slow: result=%h need %h", name, result_s, exp);
        end
        flush = 1'b1;
        flush_data = 32'h0;
        tick();
        flush = 1'b0;
        valid = 1'b0;
        tick();
    endtask

    task automatic test_encrypt();
        test_vectors("enc0", 32'h00000100, 32'hFF530000, 1'b1, 32'h16ED7C63);
        test_vectors("enc1", 32'h00001110, 32'h33220000, 1'b1, 32'hC39382CA);
    endtask

    task automatic test_decrypt();
        test_vectors("dec0", 32'h00007C63, 32'h16ED0000, 1'b0, 32'hFF530100);
        test_vectors("dec1", 32'h000082CA, 32'hC3930000, 1'b0, 32'h33221110);
    endtask

    task automatic test_roundtrip();
        logic [31:0] a, b, r, back;
        int lat;
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom;
            run_op(a, b, 1'b1, r, lat);
            run_op({16'h0, r[15:0]}, {r[31:16], 16'h0}, 1'b0, back, lat);
            n_tests++;
            if (back !== {b[31:16], a[15:0]} || lat != 4) begin
                n_fail++;
                $display("FAIL roundtrip%0d: got %h lat %0d need %h lat 4",
                         i, back, lat, {b[31:16], a[15:0]});
            end
        end
    endtask

    task automatic test_flush_mid();
        bit seen = 1'b0;
        rs1 = 32'h00000100; rs2 = 32'hFF530000; enc = 1'b1;
        valid = 1'b1;
        tick();
        seen |= ready_s;
        tick();
        seen |= ready_s;
        flush = 1'b1;
        flush_data = 32'hA5A5A5A5;
        tick();
        seen |= ready_s;
        flush = 1'b0;
        valid = 1'b0;
        n_tests++;
        if (result_s !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL flush_mid_data: result=%h need a5a5a5a5", result_s);
        end
        tick();
        seen |= ready_s;
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_mid_ready: ready seen=%b need 0", seen);
        end
    endtask

    task automatic test_retire_reissue();
        rs1 = 32'h00000100; rs2 = 32'hFF530000; enc = 1'b1;
        valid = 1'b1;
        for (int c = 1; c <= 4; c++) tick();
        n_tests++;
        if (ready_s !== 1'b1) begin
            n_fail++;
            $display("FAIL reissue_first_ready: ready=%b need 1", ready_s);
        end
        flush = 1'b1;
        flush_data = 32'h5A5A0F0F;
        tick();
        flush = 1'b0;
        n_tests++;
        if (ready_s !== 1'b0 || result_s !== 32'h5A5A0F0F) begin
            n_fail++;
            $display("FAIL reissue_gap: ready=%b result=%h need 0/5a5a0f0f",
                     ready_s, result_s);
        end
        rs1 = 32'h0; rs2 = 32'h0; enc = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_tests++;
            if (ready_s !== (c == 4)) begin
                n_fail++;
                $display("FAIL reissue_ready c%0d: ready=%b need %b",
                         c, ready_s, (c == 4));
            end
        end
        n_tests++;
        if (result_s !== 32'h63636363) begin
            n_fail++;
            $display("FAIL reissue_result: result=%h need 63636363", result_s);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        rs1 = 32'h00001110; rs2 = 32'h33220000; enc = 1'b1;
        valid = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        n_tests++;
        if (ready_s !== 1'b0 || result_s !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid: ready=%b result=%h need 0/00000000",
                     ready_s, result_s);
        end
        reset = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_tests++;
            if (ready_s !== (c == 4)) begin
                n_fail++;
                $display("FAIL reset_restart_ready c%0d: ready=%b need %b",
                         c, ready_s, (c == 4));
            end
        end
        n_tests++;
        if (result_s !== 32'hC39382CA) begin
            n_fail++;
            $display("FAIL reset_restart_result: result=%h need c39382ca",
                     result_s);
        end
        flush = 1'b1;
        flush_data = 32'h0;
        tick();
        flush = 1'b0;
        valid = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        rs1 = 32'h00001110; rs2 = 32'h33220000; enc = 1'b1;
        valid = 1'b1;
        tick();
        tick();
        valid = 1'b0;
        tick();
        n_tests++;
        if (ready_s !== 1'b0 || result_s[15:0] !== 16'h82CA) begin
            n_fail++;
            $display("FAIL abort: ready=%b low=%h need 0/82ca",
                     ready_s, result_s[15:0]);
        end
        valid = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_tests++;
            if (ready_s !== (c == 4)) begin
                n_fail++;
                $display("FAIL abort_restart c%0d: ready=%b need %b",
                         c, ready_s, (c == 4));
            end
        end
        n_tests++;
        if (result_s !== 32'hC39382CA) begin
            n_fail++;
            $display("FAIL abort_result: result=%h need c39382ca", result_s);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_roundtrip();
        test_flush_mid();
        test_retire_reissue();
        test_reset_mid();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/xc_aessub.md
Name: xc_aessub

Overview:
- Multi-cycle AES SubBytes instruction unit for the XCrypto co-processor.
- Sits directly upstream of xc_aesmix in the AES round datapath. It takes the same packed byte selection from rs1/rs2 and produces a word of S-box substituted bytes, which feeds the MixColumns step.
- Supports forward (enc) and inverse (dec) S-box.
- Two build options:
  - Area-optimised: one shared S-box, iterated over 4 cycles.
  - Fast: 4 parallel S-boxes, 1 cycle.

Parameters:
- FAST, 1'b0, 1 = four S-box instances with 1-cycle latency; 0 = one S-box instance iterated over 4 cycles.

Ports:
- clock  in  1  Core clock; all state updates on rising edge.
- reset  in  1  Synchronous reset, active-low: state cleared on the rising clock edge when reset==0.
- flush  in  1  Abandon/complete the current op; scrub internal result register.
- flush_data  in  32  Value written into the result register on flush (scrub data).
- valid  in  1  Inputs are valid; held high until ready or flush.
- rs1  in  32  Source register 1.
- rs2  in  32  Source register 2.
- enc  in  1  1 = forward S-box, 0 = inverse S-box.
- ready  out  1  Result valid this cycle.
- result  out  32  Substituted word.

Behaviour:
- Byte selection: t0=rs1[7:0], t1=rs1[15:8], t2=rs2[23:16], t3=rs2[31:24].
- result = {S(t3), S(t2), S(t1), S(t0)}, where S = FIPS-197 forward S-box if enc, inverse S-box otherwise.
- Upstream contract: rs1, rs2, enc and valid are stable while valid && !ready. The block does not re-sample them mid-op.
- Registers:
  - state (IDLE, BUSY, DONE)
  - cnt (2 bits)
  - res (32 bits); result = res
- ready = (state==DONE) && valid; purely a decode of registered state.
- Reset (reset==0 at an edge): state=IDLE, cnt=0, res=0, so ready=0 and result=0. Reset has priority over flush and valid.
- FAST=0:
  - IDLE && valid: res[7:0] <= S(t0), cnt <= 1, go to BUSY.
  - BUSY && valid: res byte[cnt] <= S(t[cnt]), cnt++. When cnt==3, go to DONE.
  - Latency: valid first high at edge N gives ready=1 in the cycle after edge N+3 (4 cycles).
- FAST=1:
  - IDLE && valid: all 4 bytes written, go to DONE.
  - Latency: ready=1 one cycle after valid is first sampled.
- DONE: holds state and res while valid && !flush; ready stays high.
- flush (any state): state <= IDLE, cnt <= 0, res <= flush_data.
  - Flush in the same cycle as ready (the normal retire, flush=valid&&ready) returns to IDLE. A new op can start on the next edge.
- valid low while BUSY/DONE without flush: abort, state <= IDLE, cnt <= 0, res retained. No ready is generated.
- Flush while BUSY: partial result discarded, res <= flush_data.
- Back-to-back ops: each op starts only from IDLE, so the minimum issue interval is latency+1 cycles.
- No combinational path from the rs1/rs2/enc inputs to ready.
- result is registered; bytes not yet written in BUSY hold their previous value and must not be consumed.

Decomposition:
- Shared package (xc_aes_pkg):
  - FSM state encoding constants: IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
  - Byte-lane index constants.
- Sub-module xc_aes_sbox: combinational 8-bit S-box.
  - Ports: in[7:0], enc, out[7:0].
  - Forward and inverse implemented as tables, or as GF(2^8) inverse plus affine / inverse-affine.
  - Instantiated once (FAST=0) or four times (FAST=1).
  - Reusable by the key-schedule block.

Test Plan:
- Encrypt: rs1=0x00000100, rs2=0xFF530000, enc=1, valid held.
  - Required: result=0x16ED7C63 with ready=1.
  - FAST=0: ready at cycle 4. FAST=1: ready at cycle 1.
- Decrypt: rs1=0x00007C63, rs2=0x16ED0000, enc=0.
  - Required: result=0xFF530100.
  - Pairwise round-trip over random words must reproduce t0..t3.
- Flush mid-op (FAST=0): valid at cycle 0, flush=1 with flush_data=0xA5A5A5A5 at cycle 2.
  - Required: state IDLE, result=0xA5A5A5A5, ready never asserted.
- Retire and reissue: ready with flush=1, then a new op on the next cycle (rs1=0x00000000, rs2=0x00000000, enc=1).
  - Required: result=0x63636363 after the full latency.
  - No stale ready in the intervening cycle.
- Reset mid-op: reset=0 at cycle 2 of a FAST=0 op.
  - Required: ready=0 and result=0 on the next cycle; op not resumed when reset=1 returns with valid still high. It restarts from IDLE and gives the full latency.
- Abort: valid dropped during BUSY without flush.
  - Required: IDLE next cycle, ready=0.
  - Equivalence: formal equivalence of FAST=0 vs FAST=1 vs the reference model, checked on valid && ready.
